// File: rtl/memory_access_stage.sv
// memory_access_stage: M-stage data memory access FSM (IDLE/BUSY) and M/W pipeline register; optional macro DMEM_TIMEOUT_EN adds a BUSY timeout abort
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic        DMemReady,
  input  logic [31:0] DMemRData,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        StallM,
  output logic        MemErrorW
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic memOp, loadOp, timeoutHit, bubble;
  assign memOp = MemReadM | MemWriteM;
  assign loadOp = MemReadM & ~MemWriteM;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) + 1 > 5) ? $clog2(TIMEOUT_CYCLES) + 1 : 5;
  logic [CW-1:0] cnt;
  assign timeoutHit = state == BUSY && cnt == CW'(TIMEOUT_CYCLES - 1) && !DMemReady;
  // Count BUSY cycles spent waiting; cleared while idle so each access starts from zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if (!DMemReady) cnt <= cnt + 1'b1;
  // Sticky error flag raised when an access is abandoned on timeout
  always_ff @(posedge clk or negedge rst)
    if (!rst) MemErrorW <= 1'b0;
    else if (timeoutHit) MemErrorW <= 1'b1;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign timeoutHit = 1'b0;
  assign MemErrorW = 1'b0;
`endif
  assign DMemReq = rst & ~timeoutHit & (state == BUSY | memOp);
  assign DMemWe = DMemReq & MemWriteM;
  assign DMemAddr = {ALU_ResultM[31:2], 2'b00};
  assign DMemWData = WriteDataM;
  assign StallM = DMemReq & ~DMemReady;
  assign bubble = StallM | timeoutHit;
  // Enter BUSY when an idle-cycle access is not ready; leave on completion or timeout
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= (state == IDLE) ? (StallM ? BUSY : IDLE) : ((DMemReady | timeoutHit) ? IDLE : BUSY);
  // M/W register: capture on completion, insert a bubble while stalled or aborted
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWriteW <= 1'b0;
      ResultSrcW <= 1'b0;
      RD_W <= '0;
      ALU_ResultW <= '0;
      ReadDataW <= '0;
      PCPlus4W <= '0;
    end else begin
      RegWriteW <= RegWriteM & ~bubble;
      ResultSrcW <= ResultSrcM & ~bubble;
      if (!bubble) begin
        RD_W <= RD_M;
        ALU_ResultW <= ALU_ResultM;
        PCPlus4W <= PCPlus4M;
        if (loadOp) ReadDataW <= DMemRData;
      end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed stimulus with a writeback scoreboard for memory_access_stage
module tb_memory_access_stage;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        rs;
  } wb_t;
  logic clk = 0;
  logic rst = 1;
  logic RegWriteM = 0, MemReadM = 0, MemWriteM = 0, ResultSrcM = 0;
  logic [4:0] RD_M = 0;
  logic [31:0] ALU_ResultM = 0, WriteDataM = 0, PCPlus4M = 0;
  logic DMemReq, DMemWe, DMemReady = 0;
  logic [31:0] DMemAddr, DMemWData, DMemRData = 0;
  logic RegWriteW, ResultSrcW, StallM, MemErrorW;
  logic [4:0] RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;
  int tests = 0, fails = 0;
  wb_t q[$];
  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemReady(DMemReady), .DMemRData(DMemRData),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .StallM(StallM), .MemErrorW(MemErrorW)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic rw, input logic rdOp, input logic wrOp, input logic rs,
                       input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] expAddr,
                       input logic [31:0] expRead, input int waits);
    logic op;
    op = rdOp | wrOp;
    RegWriteM = rw; MemReadM = rdOp; MemWriteM = wrOp; ResultSrcM = rs;
    RD_M = dst; ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc;
    for (int c = 0; c <= waits; c++) begin
      DMemReady = (c == waits);
      DMemRData = (c == waits) ? rdata : 32'hBAD0BAD0;
      #3;
      chk("DMemReq", DMemReq, op);
      chk("StallM", StallM, op && c < waits);
      if (op && c == 0) begin
        chk("DMemAddr", DMemAddr, expAddr);
        chk("DMemWe", DMemWe, wrOp);
        chk("DMemWData", DMemWData, wd);
      end
      if (c > 0) chk("bubble RegWriteW", RegWriteW, 0);
      if (c == waits && rw) q.push_back('{rd: dst, alu: alu, rdata: expRead, pc: pc, rs: rs});
      @(posedge clk); #1;
    end
  endtask
  // Scoreboard monitor: every writeback must match the oldest expected entry
  always @(negedge clk) begin
    wb_t e;
    if (rst && RegWriteW) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected writeback: RD_W=%0d ALU_ResultW=%h expected none", RD_W, ALU_ResultW);
      end else begin
        e = q.pop_front();
        chk("wb RD_W", RD_W, e.rd);
        chk("wb ALU_ResultW", ALU_ResultW, e.alu);
        chk("wb ReadDataW", ReadDataW, e.rdata);
        chk("wb PCPlus4W", PCPlus4W, e.pc);
        chk("wb ResultSrcW", ResultSrcW, e.rs);
      end
    end
  end
  initial begin
    #1 rst = 0;
    MemReadM = 1; DMemReady = 1;
    #2;
    chk("reset DMemReq", DMemReq, 0);
    chk("reset StallM", StallM, 0);
    chk("reset RegWriteW", RegWriteW, 0);
    chk("reset ALU_ResultW", ALU_ResultW, 0);
    chk("reset ReadDataW", ReadDataW, 0);
    chk("reset MemErrorW", MemErrorW, 0);
    MemReadM = 0;
    @(posedge clk); @(posedge clk); #1 rst = 1;
    issue(1, 1, 0, 1, 5'd5, 32'h00000104, 32'h0, 32'h1000, 32'hDEADBEEF, 32'h00000104, 32'hDEADBEEF, 0);
    issue(1, 0, 0, 0, 5'd6, 32'h00000055, 32'h0, 32'h1004, 32'h77777777, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 0, 1, 0, 5'd7, 32'h00000203, 32'h12345678, 32'h1008, 32'h0, 32'h00000200, 32'hDEADBEEF, 3);
    issue(1, 1, 0, 1, 5'd9, 32'h00000301, 32'h0, 32'h100C, 32'hCAFEF00D, 32'h00000300, 32'hCAFEF00D, 2);
    issue(1, 1, 1, 0, 5'd10, 32'h00000010, 32'h0000AAAA, 32'h1010, 32'h11111111, 32'h00000010, 32'hCAFEF00D, 0);
    RegWriteM = 1; MemReadM = 1; MemWriteM = 0; RD_M = 11; ALU_ResultM = 32'h400; DMemReady = 0;
    @(posedge clk); @(posedge clk); #1;
    #2 rst = 0;
    #1;
    chk("rst busy DMemReq", DMemReq, 0);
    chk("rst busy StallM", StallM, 0);
    chk("rst busy RegWriteW", RegWriteW, 0);
    chk("rst busy MemErrorW", MemErrorW, 0);
    @(posedge clk); #1 rst = 1;
    issue(1, 1, 0, 1, 5'd3, 32'h00000406, 32'h0, 32'h2000, 32'h13572468, 32'h00000404, 32'h13572468, 0);
`ifdef DMEM_TIMEOUT_EN
    RegWriteM = 1; MemReadM = 1; MemWriteM = 0; ResultSrcM = 1; RD_M = 12; ALU_ResultM = 32'h500; DMemReady = 0;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("timeout StallM", StallM, c < 4);
      chk("timeout DMemReq", DMemReq, c < 4);
      chk("timeout MemErrorW early", MemErrorW, 0);
      @(posedge clk); #1;
    end
    RegWriteM = 0; MemReadM = 0;
    #3;
    chk("timeout MemErrorW set", MemErrorW, 1);
    chk("timeout RegWriteW bubble", RegWriteW, 0);
    @(posedge clk); #4;
    chk("timeout MemErrorW sticky", MemErrorW, 1);
`else
    issue(1, 1, 0, 1, 5'd12, 32'h00000500, 32'h0, 32'h3000, 32'h24681357, 32'h00000500, 32'h24681357, 8);
    chk("no timeout MemErrorW", MemErrorW, 0);
`endif
    RegWriteM = 0; MemReadM = 0; MemWriteM = 0; DMemReady = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("scoreboard drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of BUSY cycles without DMemReady before abort (used only with DMEM_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have M-stage inputs: RegWriteM, MemReadM, MemWriteM, ResultSrcM  in  1  control from execute register; RD_M  in  5  destination; ALU_ResultM  in  32  address/ALU result; WriteDataM  in  32  store data; PCPlus4M  in  32  return address.
REQ-004 SHALL have memory bus: DMemReq  out  1  access request; DMemWe  out  1  write enable; DMemAddr  out  32  word address; DMemWData  out  32  store data; DMemReady  in  1  access complete; DMemRData  in  32  load data, valid when DMemReady=1.
REQ-005 SHALL have W-stage outputs: RegWriteW, ResultSrcW  out  1; RD_W  out  5; ALU_ResultW, ReadDataW, PCPlus4W  out  32.
REQ-006 SHALL have StallM  out  1  freeze request to fetch/decode/execute; MemErrorW  out  1  sticky access-timeout flag.

Function
REQ-007 SHALL implement FSM with states IDLE and BUSY.
REQ-008 Memory op present = MemReadM | MemWriteM; if both set, write SHALL take precedence (DMemWe=1).
REQ-009 In IDLE with memory op: DMemReq=1 combinationally same cycle; DMemWe=MemWriteM; DMemAddr={ALU_ResultM[31:2],2'b00}; DMemWData=WriteDataM.
REQ-010 IDLE, op, DMemReady=1: access completes zero-wait, StallM=0, stay IDLE.
REQ-011 IDLE, op, DMemReady=0: StallM=1, next state BUSY.
REQ-012 BUSY: DMemReq held 1 with same DMemWe/DMemAddr/DMemWData (upstream holds M inputs stable while StallM=1); StallM=~DMemReady; on DMemReady=1 return to IDLE.
REQ-013 No memory op in IDLE: DMemReq=0, DMemWe=0, StallM=0.
REQ-014 StallM SHALL be combinational (0-cycle) from DMemReady and state.
REQ-015 M/W register SHALL load on every rising clk; when StallM=0 it captures RegWriteM, ResultSrcM, RD_M, ALU_ResultM, PCPlus4M, and ReadDataW<=DMemRData if the completing access is a load, else ReadDataW holds.
REQ-016 When StallM=1, W register SHALL load a bubble: RegWriteW<=0, ResultSrcW<=0, data fields hold; no instruction writes back twice.
REQ-017 Load-to-writeback latency SHALL be 1 cycle after the DMemReady cycle.
REQ-018 DMemReady while DMemReq=0 SHALL be ignored.

Reset
REQ-019 rst=0 SHALL asynchronously force IDLE, all W outputs to 0, MemErrorW=0, timeout counter 0.
REQ-020 Reset during BUSY SHALL drop DMemReq and StallM immediately (combinationally from state); outstanding access abandoned.
REQ-021 After rst deasserts, first access SHALL start no earlier than the first rising clk with rst=1.

Configuration
REQ-022 Macro DMEM_TIMEOUT_EN defined: 5-bit-or-wider counter clears on IDLE->BUSY, increments each BUSY cycle without DMemReady; in the BUSY cycle where counter = TIMEOUT_CYCLES-1 and DMemReady=0: DMemReq=0, StallM=0, next IDLE, W loads bubble, MemErrorW<=1 (sticky until reset).
REQ-023 Macro not defined: no counter; BUSY waits indefinitely; MemErrorW tied 0.

Verification
REQ-024 Load, ALU_ResultM=0x00000104, DMemReady=1 same cycle, DMemRData=0xDEADBEEF -> StallM=0, DMemAddr=0x00000104, next cycle ReadDataW=0xDEADBEEF, RegWriteW=1, RD_W=RD_M.
REQ-025 Store, ALU_ResultM=0x00000203, WriteDataM=0x12345678, DMemReady low 3 cycles -> DMemAddr=0x00000200, DMemWe=1, StallM=1 for 3 cycles, W gets 3 bubbles (RegWriteW=0), completes on 4th cycle.
REQ-026 Back-to-back zero-wait load then ALU op (MemReadM=0, ALU_ResultM=0x55) -> no stall; second cycle DMemReq=0, ALU_ResultW=0x55 one cycle later.
REQ-027 rst=0 asserted in 2nd BUSY cycle -> DMemReq, StallM, RegWriteW, MemErrorW all 0 immediately without clock edge; first access after release behaves per REQ-009.
REQ-028 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, DMemReady never asserted -> StallM=1 for 4 cycles (IDLE + 3 BUSY), released in 5th (4th BUSY), MemErrorW=1 next edge and held; without macro StallM stays 1 indefinitely, MemErrorW=0.
